// File: rtl/ram_bist_pkg.sv
// Shared types and March C- element table for the RAM BIST controller.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CHECK,
    FIN
  } state_t;

  localparam int unsigned NUM_ELEM = 6;
  localparam int unsigned ELEM_W   = 3;
  localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(NUM_ELEM - 1);

  // March C-: E0 up W0; E1 up R0,W1; E2 up R1,W0; E3 down R0,W1; E4 down R1,W0; E5 down R0.
  // Bit n of each vector describes element n.
  localparam logic [NUM_ELEM-1:0] HAS_READ  = 6'b111110;
  localparam logic [NUM_ELEM-1:0] HAS_WRITE = 6'b011111;
  localparam logic [NUM_ELEM-1:0] DIR_DOWN  = 6'b111000;
  localparam logic [NUM_ELEM-1:0] EXPECT_BG = 6'b010100;
  localparam logic [NUM_ELEM-1:0] WRITE_BG  = 6'b001010;

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter with load and last-address flag for the BIST walk.
module ram_bist_addr_gen #(
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

  // Load picks the start address of the next element; step walks the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? TOP_ADDR : '0;
    end else if (step) begin
      addr <= down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  // Final address of the walk in the current direction; never runs past DEPTH-1.
  always_comb begin
    last_c = down ? (addr == '0) : (addr == TOP_ADDR);
  end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST engine driving a single-port synchronous RAM.
// Optional BIST_ERR_LOG_EN: keep running past mismatches and count them in err_count.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 4,
  parameter  int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_write_enable,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
`ifdef BIST_ERR_LOG_EN
  ,
  output logic [7:0]            err_count
`endif
);

  state_t                  state;
  logic [ELEM_W-1:0]       elem;
  logic [ELEM_W-1:0]       nxt_idx;
  logic [ADDR_W-1:0]       addr;
  logic                    last_c;
  logic                    load;
  logic                    load_down;
  logic                    step;
  logic [DATA_WIDTH-1:0]   expect_word;
  logic                    mismatch_c;
  logic                    err_any_c;
`ifdef BIST_ERR_LOG_EN
  logic                    err_seen;
`endif

  ram_bist_addr_gen #(
    .DEPTH(DEPTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_down (load_down),
    .step      (step),
    .down      (DIR_DOWN[elem]),
    .addr      (addr),
    .last_c    (last_c)
  );

  assign mem_addr = addr;

  // RAM strobes, compare and address-walk control. The write in CHECK must see the
  // compare result of the same cycle, so it stays combinational off the state registers.
  always_comb begin
    nxt_idx          = (elem == LAST_ELEM) ? elem : ELEM_W'(elem + 1'b1);
    expect_word      = {DATA_WIDTH{EXPECT_BG[elem]}};
    mem_data_in      = {DATA_WIDTH{WRITE_BG[elem]}};
    mismatch_c       = (state == CHECK) && (mem_data_out != expect_word);
    mem_write_enable = 1'b0;
    load             = 1'b0;
    load_down        = 1'b0;
    step             = 1'b0;
`ifdef BIST_ERR_LOG_EN
    err_any_c        = err_seen || mismatch_c;
`else
    err_any_c        = 1'b0;
`endif
    case (state)
      IDLE: begin
        load = start;
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        load             = last_c;
        load_down        = DIR_DOWN[nxt_idx];
        step             = !last_c;
      end
      CHECK: begin
`ifdef BIST_ERR_LOG_EN
        mem_write_enable = HAS_WRITE[elem];
`else
        mem_write_enable = HAS_WRITE[elem] && !mismatch_c;
`endif
        load             = last_c;
        load_down        = DIR_DOWN[nxt_idx];
        step             = !last_c;
      end
      default: ;
    endcase
  end

  // Test sequencer: element/state progression and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      elem      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
`ifdef BIST_ERR_LOG_EN
      err_count <= '0;
      err_seen  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            elem      <= '0;
            state     <= HAS_READ[0] ? READ : WRITE;
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
`ifdef BIST_ERR_LOG_EN
            err_count <= '0;
            err_seen  <= 1'b0;
`endif
          end
        end
        WRITE: begin
          if (last_c) begin
            elem  <= nxt_idx;
            state <= HAS_READ[nxt_idx] ? READ : WRITE;
          end
        end
        READ: begin
          state <= CHECK;
        end
        CHECK: begin
`ifdef BIST_ERR_LOG_EN
          // Log every mismatch, keep only the first failing address/data.
          if (mismatch_c) begin
            if (!err_seen) begin
              fail_addr <= addr;
              fail_data <= mem_data_out;
            end
            err_seen <= 1'b1;
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end
          if (last_c && (elem == LAST_ELEM)) begin
`else
          // First mismatch aborts the test.
          if (mismatch_c) begin
            fail_addr <= addr;
            fail_data <= mem_data_out;
            fail      <= 1'b1;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= FIN;
          end else if (last_c && (elem == LAST_ELEM)) begin
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !err_any_c;
            fail  <= err_any_c;
            state <= FIN;
          end else if (last_c) begin
            elem  <= nxt_idx;
            state <= HAS_READ[nxt_idx] ? READ : WRITE;
          end else begin
            state <= READ;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a behavioural 16x4 RAM and switchable faults.
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mem_write_enable;
  logic [3:0] mem_addr;
  logic [3:0] mem_data_in;
  logic [3:0] ram_q;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fail;
  logic [3:0] fail_addr;
  logic [3:0] fail_data;
`ifdef BIST_ERR_LOG_EN
  logic [7:0] err_count;
`endif

  logic [3:0] mem [16];
  logic       clr_mem;
  logic       sa_fault;
  logic       cpl_fault;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc;

  always #5 clk = ~clk;

  ram_bist_ctrl #(
    .DATA_WIDTH(4),
    .DEPTH     (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .mem_write_enable (mem_write_enable),
    .mem_addr         (mem_addr),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (ram_q),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .fail             (fail),
    .fail_addr        (fail_addr),
    .fail_data        (fail_data)
`ifdef BIST_ERR_LOG_EN
    ,
    .err_count        (err_count)
`endif
  );

  // RAM model: addr 5 bit0 stuck-at-1 on read; write to addr 3 flips bit2 of addr 4.
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'h0;
    end else if (mem_write_enable) begin
      mem[mem_addr] <= mem_data_in;
      if (cpl_fault && mem_addr == 4'd3) mem[4] <= mem[4] ^ 4'h4;
    end
    ram_q <= mem[mem_addr] | ((sa_fault && mem_addr == 4'd5) ? 4'h1 : 4'h0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_ram();
    @(negedge clk) clr_mem = 1'b1;
    @(negedge clk) clr_mem = 1'b0;
  endtask

  // Pulse start, then count busy cycles; optionally poke start mid-run or stop early.
  task automatic run_bist(input int stop_at, input bit poke, output int cycles);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cycles = 0;
    while (busy && cycles < 1000) begin
      cycles++;
      start = (poke && cycles == 50);
      if (stop_at != 0 && cycles == stop_at) return;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    clr_mem   = 1'b0;
    sa_fault  = 1'b0;
    cpl_fault = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_fail", fail, 0);
    check_eq("rst_we", mem_write_enable, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_fail_addr", fail_addr, 0);
    @(negedge clk) rst = 1'b0;

    // Clean run: 176 busy cycles then a done pulse with pass.
    clear_ram();
    run_bist(0, 1'b0, cyc);
    check_eq("t1_cycles", cyc, 176);
    check_eq("t1_done", done, 1);
    check_eq("t1_pass", pass, 1);
    check_eq("t1_fail", fail, 0);
    @(negedge clk);
    check_eq("t1_done_low", done, 0);
    check_eq("t1_ram7", mem[7], 0);

    // start while busy and coincident with done must be ignored.
    clear_ram();
    run_bist(0, 1'b1, cyc);
    check_eq("t5_cycles", cyc, 176);
    check_eq("t5_done", done, 1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_eq("t5_busy_a", busy, 0);
    @(negedge clk);
    check_eq("t5_busy_b", busy, 0);
    check_eq("t5_pass", pass, 1);

`ifndef BIST_ERR_LOG_EN
    // Stuck-at-1 bit0 at addr 5: caught in E1 after 16 + 2*6 cycles, write suppressed.
    clear_ram();
    sa_fault = 1'b1;
    run_bist(0, 1'b0, cyc);
    check_eq("t2_cycles", cyc, 28);
    check_eq("t2_done", done, 1);
    check_eq("t2_fail", fail, 1);
    check_eq("t2_pass", pass, 0);
    check_eq("t2_fail_addr", fail_addr, 5);
    check_eq("t2_fail_data", fail_data, 4'h1);
    check_eq("t2_ram4", mem[4], 4'hF);
    check_eq("t2_ram5", mem[5], 4'h0);
    check_eq("t2_ram6", mem[6], 4'h0);
    sa_fault = 1'b0;

    // Coupling fault 3 -> 4 bit2: caught in E1 at addr 4.
    clear_ram();
    cpl_fault = 1'b1;
    run_bist(0, 1'b0, cyc);
    check_eq("t3_cycles", cyc, 26);
    check_eq("t3_fail", fail, 1);
    check_eq("t3_fail_addr", fail_addr, 4);
    check_eq("t3_fail_data", fail_data, 4'h4);
    cpl_fault = 1'b0;
`endif

    // Reset at busy cycle 40 (E1 CHECK of addr 11), then a fresh clean run.
    clear_ram();
    run_bist(40, 1'b0, cyc);
    check_eq("t4_pre_busy", busy, 1);
    check_eq("t4_pre_we", mem_write_enable, 1);
    check_eq("t4_pre_addr", mem_addr, 11);
    rst = 1'b1;
    #1;
    check_eq("t4_busy", busy, 0);
    check_eq("t4_we", mem_write_enable, 0);
    check_eq("t4_addr", mem_addr, 0);
    check_eq("t4_data_in", mem_data_in, 0);
    check_eq("t4_done", done, 0);
    @(negedge clk) rst = 1'b0;
    clear_ram();
    run_bist(0, 1'b0, cyc);
    check_eq("t4_cycles", cyc, 176);
    check_eq("t4_pass", pass, 1);

`ifdef BIST_ERR_LOG_EN
    // Logging build: stuck-at fault seen in E1, E3, E5; full-length run.
    clear_ram();
    sa_fault = 1'b1;
    run_bist(0, 1'b0, cyc);
    check_eq("t6_cycles", cyc, 176);
    check_eq("t6_err_count", err_count, 3);
    check_eq("t6_fail", fail, 1);
    check_eq("t6_pass", pass, 0);
    check_eq("t6_fail_addr", fail_addr, 5);
    check_eq("t6_fail_data", fail_data, 4'h1);
    sa_fault = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
